// File: rtl/watch_timekeeper.sv
// Watch timekeeping core: 24-hour time of day plus a saturating stopwatch, both ticked at 1 Hz from CLK_HZ.
// Optional lap hold is compiled in with `define WATCH_LAP_EN.
module watch_timekeeper #(
    parameter int CLK_HZ = 32768
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] state,
    input  logic       btn_inc,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [5:0] current_s,
    output logic [5:0] current_m,
    output logic [5:0] current_h,
    output logic [5:0] stopwatch_s,
    output logic [5:0] stopwatch_m,
    output logic [5:0] stopwatch_h,
    output logic       second,
    output logic       sw_running,
    output logic       lap_active
);
    localparam int PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] P_LAST = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2);
    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [17:0]   SW_MAX = {6'd23, 6'd59, 6'd59};

    // {h, m, s} advanced by one second with minute/hour carries, wrapping at midnight
    function automatic logic [17:0] hms_advance(input logic [17:0] t);
        logic [5:0] h, m, s;
        {h, m, s} = t;
        if (s != 6'd59) begin
            s = s + 6'd1;
        end else begin
            s = 6'd0;
            if (m != 6'd59) begin
                m = m + 6'd1;
            end else begin
                m = 6'd0;
                h = (h == 6'd23) ? 6'd0 : h + 6'd1;
            end
        end
        return {h, m, s};
    endfunction

    logic [PW-1:0] tp_q, tp_d, sp_q, sp_d;
    logic [17:0]   tod_q, tod_d, sw_q, sw_d;
    logic          second_q, second_d, run_q, run_d;
    logic          set_mode, sw_mode, tick, sw_tick;
`ifdef WATCH_LAP_EN
    logic          lap_q, lap_d;
    logic [17:0]   disp_q, disp_d;
`else
    logic          unused_lap;
    assign unused_lap = btn_lap;
`endif

    always_comb begin
        set_mode = (state == 3'd1) || (state == 3'd2) || (state == 3'd3);
        sw_mode  = (state == 3'd4);
        tick     = !set_mode && (tp_q == P_LAST);
        tp_d     = (set_mode || tick) ? '0 : tp_q + P_ONE;
        second_d = !set_mode && (tp_d < P_HALF);

        tod_d = tod_q;
        if (tick) begin
            tod_d = hms_advance(tod_q);
        end else if (btn_inc) begin
            case (state)
                3'd1: tod_d[17:12] = (tod_q[17:12] == 6'd23) ? 6'd0 : tod_q[17:12] + 6'd1;
                3'd2: tod_d[11:6]  = (tod_q[11:6] == 6'd59) ? 6'd0 : tod_q[11:6] + 6'd1;
                3'd3: tod_d[5:0]   = 6'd0;
                default: ;
            endcase
        end

        // Stopwatch counts in every mode; only its buttons are gated by sw_mode
        sw_tick = run_q && (sp_q == P_LAST);
        sp_d    = run_q ? ((sp_q == P_LAST) ? '0 : sp_q + P_ONE) : sp_q;
        sw_d    = (sw_tick && (sw_q != SW_MAX)) ? hms_advance(sw_q) : sw_q;
        run_d   = run_q;
`ifdef WATCH_LAP_EN
        lap_d   = lap_q;
`endif
        if (sw_mode && btn_clear) begin
            sw_d  = '0;
            sp_d  = '0;
            run_d = 1'b0;
`ifdef WATCH_LAP_EN
            lap_d = 1'b0;
`endif
        end else begin
            if (sw_mode && btn_start) run_d = !run_q;
`ifdef WATCH_LAP_EN
            if (sw_mode && btn_lap && run_q) lap_d = !lap_q;
`endif
        end
`ifdef WATCH_LAP_EN
        // Engaging captures the count of this edge; holding freezes the display
        disp_d = (lap_d && lap_q) ? disp_q : sw_d;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tp_q     <= '0;
            sp_q     <= '0;
            tod_q    <= '0;
            sw_q     <= '0;
            second_q <= 1'b0;
            run_q    <= 1'b0;
`ifdef WATCH_LAP_EN
            lap_q    <= 1'b0;
            disp_q   <= '0;
`endif
        end else begin
            tp_q     <= tp_d;
            sp_q     <= sp_d;
            tod_q    <= tod_d;
            sw_q     <= sw_d;
            second_q <= second_d;
            run_q    <= run_d;
`ifdef WATCH_LAP_EN
            lap_q    <= lap_d;
            disp_q   <= disp_d;
`endif
        end
    end

    assign current_h  = tod_q[17:12];
    assign current_m  = tod_q[11:6];
    assign current_s  = tod_q[5:0];
    assign second     = second_q;
    assign sw_running = run_q;
`ifdef WATCH_LAP_EN
    assign lap_active  = lap_q;
    assign stopwatch_h = disp_q[17:12];
    assign stopwatch_m = disp_q[11:6];
    assign stopwatch_s = disp_q[5:0];
`else
    assign lap_active  = 1'b0;
    assign stopwatch_h = sw_q[17:12];
    assign stopwatch_m = sw_q[11:6];
    assign stopwatch_s = sw_q[5:0];
`endif
endmodule

// File: doc/watch_timekeeper.md
# watch_timekeeper

Timekeeping core of the wristwatch: a 24-hour time-of-day counter and an independent stopwatch, both advanced by 1 Hz ticks divided down from the system clock. It consumes the mode code from watch_fsm and debounced single-cycle button pulses, and drives the binary `current_*` / `stopwatch_*` fields and the `second` blink signal that the seven-segment display driver decodes.

## Interface
- `CLK_HZ`, default 32768: system clock cycles per second, ≥ 2. Prescaler width is $clog2(CLK_HZ).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state.
- `state`  in  3  mode from watch_fsm:
  - 0 TIME; 1 SET_HOUR; 2 SET_MIN; 3 SET_SEC; 4 STOPWATCH; 5 ALARM.
  - 5, 6 and 7 behave as TIME.
- `btn_inc`  in  1  one-cycle pulse: increment the selected field.
- `btn_start`  in  1  one-cycle pulse: stopwatch run/stop toggle.
- `btn_clear`  in  1  one-cycle pulse: stopwatch clear.
- `btn_lap`  in  1  one-cycle pulse: lap hold toggle (see Configuration).
- `current_s`, `current_m`, `current_h`  out  6 each  time of day, binary; s 0–59, m 0–59, h 0–23.
- `stopwatch_s`, `stopwatch_m`, `stopwatch_h`  out  6 each  displayed stopwatch value, binary; same ranges as the time of day.
- `second`  out  1  1 Hz blink: high while prescaler < CLK_HZ/2.
- `sw_running`  out  1  stopwatch running.
- `lap_active`  out  1  lap hold engaged.

## Operation
- Reset: all outputs 0, both prescalers 0, stopwatch stopped, lap hold cleared. Reset takes effect immediately, including mid-operation.
- Time prescaler `tp`:
  - In TIME-class states it counts 0..CLK_HZ-1 and wraps.
  - `tick` is asserted when `tp == CLK_HZ-1`.
- On `tick`, seconds increment. Carries:
  - s 59→0 increments m.
  - m 59→0 increments h.
  - h 23→0; 23:59:59 → 00:00:00.
- Set modes (1–3): `tp` is held at 0 and the time of day is frozen. `btn_inc` acts by mode:
  - SET_HOUR: h+1, 23→0.
  - SET_MIN: m+1, 59→0, no carry into h.
  - SET_SEC: s←0.
- `btn_inc` is ignored in all other states.
- Leaving a set mode: `tp` restarts from 0, so the first tick comes CLK_HZ cycles later.
- Stopwatch uses its own prescaler `sp`:
  - `sp` runs only while `sw_running`.
  - Its tick advances the stopwatch count with the same carries as the time of day.
  - At 23:59:59 the count saturates (holds) instead of wrapping.
- Stopwatch buttons are honored only when `state == 4`. The count keeps running in every state.
  - `btn_start` toggles `sw_running` and leaves `sp` unchanged (pause/resume).
  - `btn_clear` zeroes the count and `sp`, stops the stopwatch, and clears lap hold.
  - If `btn_clear` and `btn_start` arrive in the same cycle, `btn_clear` wins and `btn_start` is dropped.
- Simultaneous `tick` and `btn_inc` cannot conflict: `tick` never fires in set modes.

## Timing
- All outputs are registered. A tick or button at edge N is visible after edge N.
- Time of day and stopwatch advance exactly once per CLK_HZ enabled cycles.
- `second` toggles at `tp == CLK_HZ/2` and at wrap. It is held low in set modes.
- Button pulses are sampled on every edge; a pulse held for k cycles acts k times.

## Configuration
- `WATCH_LAP_EN` defined:
  - `btn_lap` with `state == 4` and `sw_running` toggles lap hold.
  - On engage, the current count is captured. `stopwatch_*` show the captured value while the internal count keeps running.
  - Release shows the live count on the next cycle.
  - `lap_active` reflects the hold.
  - `btn_lap` while stopped is ignored.
- `WATCH_LAP_EN` undefined: `btn_lap` is ignored, `lap_active` is tied 0, and `stopwatch_*` always show the live count.

## Test plan
All scenarios run with CLK_HZ=4.
- Reset low mid-count at 12:34:56 → all outputs 0 immediately. After release, `current_s` = 1 after 4 cycles and `second` is high for cycles 0–1.
- Preload via set modes to 23:59:58, return to TIME, run 8 cycles → 00:00:00, with carries into m and h on the same edge.
- SET_MIN at m=59, one `btn_inc` → m=0 and h unchanged. In SET_SEC, `btn_inc` → s=0. Time stays frozen across 20 cycles in set modes.
- State 4: `btn_start`, 10 cycles, `btn_start` → stopwatch_s = 2 and `sw_running` = 0. Same-cycle `btn_clear` + `btn_start` → 0 and stopped. `btn_start` in state 0 → no effect.
- Stopwatch preloaded near 23:59:59 via a long run (or force) → it holds at 23:59:59.
- With `WATCH_LAP_EN`: run to s=3, `btn_lap`, run 8 cycles → output stays 3 and `lap_active` = 1. Second `btn_lap` → output 5. Without the macro, `btn_lap` leaves the output tracking live.
